// File: rtl/rfphoenix_issue_scoreboard_pkg.sv
// Shared types for the issue stage: instruction format, decode bus, register ids
// and the small helpers used to derive scoreboard indices from an instruction.
package rfphoenix_issue_scoreboard_pkg;

    localparam int NREGS_DEF  = 128;
    localparam int MAX_MC_DEF = 2;

    typedef enum logic [6:0] {
        OP_NOP = 7'h00,
        OP_ADD = 7'h04,
        OP_SUB = 7'h05,
        OP_AND = 7'h08,
        OP_LDB = 7'h40,
        OP_LDW = 7'h41,
        OP_LDT = 7'h42,
        OP_STB = 7'h48,
        OP_STW = 7'h49,
        OP_STT = 7'h4A,
        OP_FMA = 7'h60,
        OP_FMS = 7'h61
    } opcode_e;

    typedef logic [6:0] sRegId;

    typedef struct packed {
        opcode_e    opcode;
        logic       tt;
        logic [5:0] rt;
        logic       ta;
        logic [5:0] ra;
        logic       tb;
        logic [5:0] rb;
        logic       tc;
        logic [5:0] rc;
    } Instruction;

    typedef struct packed {
        logic       multicycle;
        logic       load;
        logic       store;
        logic       fma;
        logic       rfwr;
        logic [3:0] aluop;
    } sDecodeBus;

    typedef struct packed {
        Instruction ir;
        sDecodeBus  deco;
    } sIssueBus;

    function automatic logic fnIsStore(Instruction ir);
        return (ir.opcode == OP_STB) || (ir.opcode == OP_STW) || (ir.opcode == OP_STT);
    endfunction

    function automatic sRegId fnRegId(logic t, logic [5:0] r);
        return {t, r};
    endfunction

endpackage

// File: rtl/rfphoenix_issue_scoreboard_if.sv
// Decoder-to-execute issue bundle plus writeback/flush sideband; the issue stage
// sits on the slave side, the surrounding pipeline on the master side.
interface rfphoenix_issue_scoreboard_if
    import rfphoenix_issue_scoreboard_pkg::*;
#(
    parameter int NREGS = NREGS_DEF
);
    logic             dec_valid;
    logic             dec_ready;
    Instruction       dec_ir;
    sDecodeBus        dec_deco;
    logic             iss_valid;
    logic             iss_ready;
    Instruction       iss_ir;
    sDecodeBus        iss_deco;
    logic             wb_v;
    sRegId            wb_reg;
    logic             mcwb_v;
    sRegId            mcwb_reg;
    logic             flush;
    logic [NREGS-1:0] busy_o;

    modport master (
        output dec_valid, dec_ir, dec_deco, iss_ready,
        output wb_v, wb_reg, mcwb_v, mcwb_reg, flush,
        input  dec_ready, iss_valid, iss_ir, iss_deco, busy_o
    );

    modport slave (
        input  dec_valid, dec_ir, dec_deco, iss_ready,
        input  wb_v, wb_reg, mcwb_v, mcwb_reg, flush,
        output dec_ready, iss_valid, iss_ir, iss_deco, busy_o
    );
endinterface

// File: rtl/rfphoenix_scoreboard.sv
// Per-register busy bits: one set port, two writeback clear ports and a flush clear.
// Read ports see this cycle's clears so a writeback unblocks a consumer immediately.
module rfphoenix_scoreboard
    import rfphoenix_issue_scoreboard_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr0_v,
    input  sRegId                 clr0_id,
    input  logic                  clr1_v,
    input  sRegId                 clr1_id,
    input  logic                  set_v,
    input  sRegId                 set_id,
    input  logic                  fclr_v,
    input  sRegId                 fclr_id,
    input  sRegId [NRD-1:0]       rd_id,
    output logic  [NRD-1:0]       rd_busy,
    output logic  [NREGS-1:0]     busy
);

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] set_vec;

    // A set and a clear on the same id resolve to set: the new producer owns it.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
            assign clr_vec[gi] = (clr0_v && (clr0_id == sRegId'(gi)))
                              || (clr1_v && (clr1_id == sRegId'(gi)))
                              || (fclr_v && (fclr_id == sRegId'(gi)));
            if (gi == 0) begin : g_zero
                assign set_vec[gi] = 1'b0;
            end else begin : g_set
                assign set_vec[gi] = set_v && (set_id == sRegId'(gi));
            end
            assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            assign rd_busy[gi] = busy_reg[rd_id[gi]] & ~clr_vec[rd_id[gi]];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

endmodule

// File: rtl/rfphoenix_issue_scoreboard.sv
// Issue stage: holds a decoded instruction until its registers are hazard-free and
// the multicycle budget allows it, then hands it to execute through one registered slot.
module rfphoenix_issue_scoreboard
    import rfphoenix_issue_scoreboard_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int MAX_MC = MAX_MC_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    rfphoenix_issue_scoreboard_if.slave  bus
);

    localparam int MC_W = (MAX_MC < 2) ? 1 : $clog2(MAX_MC + 1);

    sRegId          src_a;
    sRegId          src_b;
    sRegId          src_c;
    sRegId          dst;
    sRegId [3:0]    rd_id;
    logic  [3:0]    rd_busy;
    logic           dec_is_store;
    logic           hazard;
    logic           mc_block;
    logic           iss_free;
    logic           dec_ready;
    logic           xfer;
    logic           kill;
    logic           set_v;
    logic           mcwb_v;

    logic           iss_valid_reg;
    sIssueBus       iss_bus_reg;
    sRegId          iss_set_id_reg;
    logic [MC_W-1:0] mc_cnt_reg;
    logic [MC_W-1:0] mc_cnt_next;
    logic [MC_W:0]   mc_sum;
    logic [1:0]      mc_dec;

    assign src_a        = fnRegId(bus.dec_ir.ta, bus.dec_ir.ra);
    assign src_b        = fnRegId(bus.dec_ir.tb, bus.dec_ir.rb);
    assign src_c        = fnRegId(bus.dec_ir.tc, bus.dec_ir.rc);
    assign dst          = fnRegId(bus.dec_ir.tt, bus.dec_ir.rt);
    assign rd_id        = {dst, src_c, src_b, src_a};
    assign dec_is_store = fnIsStore(bus.dec_ir);
    assign mcwb_v       = bus.mcwb_v;

    // The dst read covers store data (RAW) and WAW for every other op.
    assign hazard    = |rd_busy;
    assign mc_block  = bus.dec_deco.multicycle && (mc_cnt_reg == MC_W'(MAX_MC));
    assign iss_free  = !iss_valid_reg || bus.iss_ready;
    assign dec_ready = rst && !hazard && !mc_block && iss_free && !bus.flush;
    assign xfer      = bus.dec_valid && dec_ready;
    assign kill      = bus.flush && iss_valid_reg;
    assign set_v     = xfer && !dec_is_store && (dst != '0);

    rfphoenix_scoreboard #(
        .NREGS (NREGS),
        .NRD   (4)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .clr0_v  (bus.wb_v),
        .clr0_id (bus.wb_reg),
        .clr1_v  (bus.mcwb_v),
        .clr1_id (bus.mcwb_reg),
        .set_v   (set_v),
        .set_id  (dst),
        .fclr_v  (kill),
        .fclr_id (iss_set_id_reg),
        .rd_id   (rd_id),
        .rd_busy (rd_busy),
        .busy    (bus.busy_o)
    );

    // iss_set_id_reg remembers what the held instruction marked busy so a flush can undo it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid_reg  <= 1'b0;
            iss_bus_reg    <= '0;
            iss_set_id_reg <= '0;
        end else if (xfer) begin
            iss_valid_reg    <= 1'b1;
            iss_bus_reg.ir   <= bus.dec_ir;
            iss_bus_reg.deco <= bus.dec_deco;
            iss_set_id_reg   <= set_v ? dst : '0;
        end else if (kill || bus.iss_ready) begin
            iss_valid_reg  <= 1'b0;
        end
    end

    // Outstanding multicycle count; simultaneous +1/-1 cancels and it saturates at 0.
    always_comb begin
        mc_sum      = {1'b0, mc_cnt_reg} + (MC_W + 1)'(xfer && bus.dec_deco.multicycle);
        mc_dec      = {1'b0, mcwb_v} + {1'b0, kill && iss_bus_reg.deco.multicycle};
        mc_cnt_next = '0;
        if (mc_sum > (MC_W + 1)'(mc_dec)) begin
            mc_cnt_next = MC_W'(mc_sum - (MC_W + 1)'(mc_dec));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_cnt_reg <= '0;
        end else begin
            mc_cnt_reg <= mc_cnt_next;
        end
    end

    mcwb_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(mcwb_v && (mc_cnt_reg == '0)));

    assign bus.dec_ready = dec_ready;
    assign bus.iss_valid = iss_valid_reg;
    assign bus.iss_ir    = iss_bus_reg.ir;
    assign bus.iss_deco  = iss_bus_reg.deco;

endmodule

// File: tb/tb_rfphoenix_issue_scoreboard.sv
// Directed bench for the issue stage: expected issue-bus contents are queued on
// accept and compared when execute consumes the issue register.
module tb_rfphoenix_issue_scoreboard;
    import rfphoenix_issue_scoreboard_pkg::*;

    logic clk;
    logic rst;
    int   n_err = 0;
    int   n_chk = 0;
    sIssueBus exp_q[$];

    rfphoenix_issue_scoreboard_if ifc ();

    rfphoenix_issue_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic Instruction mk(opcode_e op, int d, int a, int b, int c);
        Instruction i;
        i = '0;
        i.opcode = op;
        {i.tt, i.rt} = 7'(d);
        {i.ta, i.ra} = 7'(a);
        {i.tb, i.rb} = 7'(b);
        {i.tc, i.rc} = 7'(c);
        return i;
    endfunction

    function automatic sDecodeBus mkdeco(opcode_e op);
        sDecodeBus d;
        d = '0;
        d.load       = (op == OP_LDB) || (op == OP_LDW) || (op == OP_LDT);
        d.store      = (op == OP_STB) || (op == OP_STW) || (op == OP_STT);
        d.fma        = (op == OP_FMA) || (op == OP_FMS);
        d.multicycle = d.load || d.store || d.fma;
        d.rfwr       = !d.store;
        d.aluop      = 4'(op);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        ifc.dec_valid = 1'b0;
        ifc.dec_ir    = '0;
        ifc.dec_deco  = '0;
        ifc.wb_v      = 1'b0;
        ifc.wb_reg    = '0;
        ifc.mcwb_v    = 1'b0;
        ifc.mcwb_reg  = '0;
        ifc.flush     = 1'b0;
    endtask

    task automatic drive(Instruction i);
        ifc.dec_valid = 1'b1;
        ifc.dec_ir    = i;
        ifc.dec_deco  = mkdeco(i.opcode);
    endtask

    task automatic push(Instruction i);
        sIssueBus e;
        e.ir   = i;
        e.deco = mkdeco(i.opcode);
        exp_q.push_back(e);
    endtask

    // Present one instruction that must be accepted in its first cycle.
    task automatic send_ok(Instruction i, string tag);
        drive(i);
        settle();
        chk(tag, 128'(ifc.dec_ready), 128'(1));
        if (ifc.dec_ready) push(i);
        tick();
        ifc.dec_valid = 1'b0;
    endtask

    task automatic wb_pulse(logic mc, int id);
        if (mc) begin
            ifc.mcwb_v = 1'b1; ifc.mcwb_reg = 7'(id);
        end else begin
            ifc.wb_v = 1'b1; ifc.wb_reg = 7'(id);
        end
        tick();
        ifc.wb_v = 1'b0;
        ifc.mcwb_v = 1'b0;
    endtask

    // Execute-side monitor: every consumed issue slot must match the queue head.
    always @(negedge clk) begin
        if (rst && ifc.iss_valid && ifc.iss_ready && !ifc.flush) begin
            chk("iss_q_nonempty", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                sIssueBus e;
                e = exp_q.pop_front();
                $display("issue op=%s rt=%0d ra=%0d", ifc.iss_ir.opcode.name(),
                         {ifc.iss_ir.tt, ifc.iss_ir.rt}, {ifc.iss_ir.ta, ifc.iss_ir.ra});
                chk("iss_bus", 128'({ifc.iss_ir, ifc.iss_deco}), 128'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic accepted;
        rst = 1'b1;
        idle();
        ifc.iss_ready = 1'b1;
        #1 rst = 1'b0;

        // reset state, decoder offering an instruction
        drive(mk(OP_ADD, 5, 1, 2, 0));
        repeat (2) tick();
        settle();
        chk("rst_dec_ready", 128'(ifc.dec_ready), 128'(0));
        chk("rst_iss_valid", 128'(ifc.iss_valid), 128'(0));
        chk("rst_busy", 128'(ifc.busy_o), 128'(0));
        chk("rst_iss_ir", 128'(ifc.iss_ir), 128'(0));
        idle();
        tick();
        rst = 1'b1;

        // RAW stall released by a same-cycle ALU writeback
        tick();
        send_ok(mk(OP_ADD, 5, 1, 2, 0), "t1_acc_first");
        drive(mk(OP_ADD, 6, 5, 3, 0));
        settle();
        chk("t1_iss_valid", 128'(ifc.iss_valid), 128'(1));
        chk("t1_busy5", 128'(ifc.busy_o[5]), 128'(1));
        chk("t1_stall0", 128'(ifc.dec_ready), 128'(0));
        tick();
        settle();
        chk("t1_stall1", 128'(ifc.dec_ready), 128'(0));
        tick();
        ifc.wb_v = 1'b1; ifc.wb_reg = 7'd5;
        settle();
        chk("t1_bypass_acc", 128'(ifc.dec_ready), 128'(1));
        if (ifc.dec_ready) push(mk(OP_ADD, 6, 5, 3, 0));
        tick();
        idle();
        settle();
        chk("t1_iss_valid2", 128'(ifc.iss_valid), 128'(1));
        chk("t1_busy_after", 128'(ifc.busy_o), 128'(1) << 6);
        tick();
        wb_pulse(1'b0, 6);
        settle();
        chk("t1_clean", 128'(ifc.busy_o), 128'(0));

        // writeback to non-busy id and to id 0, then set-wins-over-clear
        tick();
        send_ok(mk(OP_ADD, 40, 1, 2, 0), "wb_acc40");
        wb_pulse(1'b0, 41);
        wb_pulse(1'b0, 0);
        settle();
        chk("wb_nonbusy_noeffect", 128'(ifc.busy_o), 128'(1) << 40);
        tick();
        ifc.wb_v = 1'b1; ifc.wb_reg = 7'd41;
        send_ok(mk(OP_ADD, 41, 1, 2, 0), "wb_acc41");
        ifc.wb_v = 1'b0;
        settle();
        chk("wb_set_wins", 128'(ifc.busy_o), (128'(1) << 40) | (128'(1) << 41));
        tick();
        ifc.wb_v = 1'b1; ifc.wb_reg = 7'd40;
        ifc.mcwb_v = 1'b0;
        tick();
        ifc.wb_reg = 7'd41;
        tick();
        ifc.wb_v = 1'b0;
        settle();
        chk("wb_clean", 128'(ifc.busy_o), 128'(0));

        // multicycle budget
        tick();
        send_ok(mk(OP_LDW, 8, 1, 0, 0), "t2_ld8");
        send_ok(mk(OP_LDW, 9, 1, 0, 0), "t2_ld9");
        drive(mk(OP_LDW, 10, 1, 0, 0));
        settle();
        chk("t2_mc_full0", 128'(ifc.dec_ready), 128'(0));
        tick();
        settle();
        chk("t2_mc_full1", 128'(ifc.dec_ready), 128'(0));
        tick();
        ifc.mcwb_v = 1'b1; ifc.mcwb_reg = 7'd8;
        accepted = 1'b0;
        for (int k = 0; k < 4 && !accepted; k++) begin
            settle();
            if (ifc.dec_ready) begin
                accepted = 1'b1;
                push(mk(OP_LDW, 10, 1, 0, 0));
            end
            tick();
            ifc.mcwb_v = 1'b0;
        end
        ifc.dec_valid = 1'b0;
        chk("t2_third_acc", 128'(accepted), 128'(1));
        drive(mk(OP_LDW, 11, 1, 0, 0));
        settle();
        chk("t2_mc_back_to_max", 128'(ifc.dec_ready), 128'(0));
        chk("t2_busy", 128'(ifc.busy_o), (128'(1) << 9) | (128'(1) << 10));
        tick();
        ifc.dec_valid = 1'b0;
        wb_pulse(1'b1, 9);
        wb_pulse(1'b1, 10);
        settle();
        chk("t2_clean", 128'(ifc.busy_o), 128'(0));

        // store reads its data register and never marks busy
        tick();
        send_ok(mk(OP_ADD, 7, 1, 2, 0), "t3_acc7");
        drive(mk(OP_STW, 7, 1, 0, 0));
        settle();
        chk("t3_st_raw", 128'(ifc.dec_ready), 128'(0));
        tick();
        ifc.wb_v = 1'b1; ifc.wb_reg = 7'd7;
        settle();
        chk("t3_st_acc", 128'(ifc.dec_ready), 128'(1));
        if (ifc.dec_ready) push(mk(OP_STW, 7, 1, 0, 0));
        tick();
        idle();
        settle();
        chk("t3_iss_valid", 128'(ifc.iss_valid), 128'(1));
        chk("t3_busy7", 128'(ifc.busy_o[7]), 128'(0));
        tick();
        wb_pulse(1'b1, 0);
        settle();
        chk("t3_clean", 128'(ifc.busy_o), 128'(0));

        // execute backpressure
        tick();
        send_ok(mk(OP_ADD, 20, 1, 2, 0), "t4_acc20");
        ifc.iss_ready = 1'b0;
        drive(mk(OP_ADD, 21, 1, 2, 0));
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t4_bp_ready", 128'(ifc.dec_ready), 128'(0));
            chk("t4_bp_hold", 128'(ifc.iss_ir), 128'(mk(OP_ADD, 20, 1, 2, 0)));
            tick();
        end
        ifc.iss_ready = 1'b1;
        settle();
        chk("t4_release_acc", 128'(ifc.dec_ready), 128'(1));
        if (ifc.dec_ready) push(mk(OP_ADD, 21, 1, 2, 0));
        tick();
        ifc.dec_valid = 1'b0;
        wb_pulse(1'b0, 20);
        wb_pulse(1'b0, 21);

        // flush of a held multicycle op
        send_ok(mk(OP_FMA, 12, 1, 2, 3), "t5_acc_fma");
        ifc.iss_ready = 1'b0;
        settle();
        chk("t5_busy12", 128'(ifc.busy_o[12]), 128'(1));
        tick();
        ifc.flush = 1'b1;
        drive(mk(OP_ADD, 13, 1, 2, 0));
        settle();
        chk("t5_flush_no_acc", 128'(ifc.dec_ready), 128'(0));
        tick();
        idle();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        settle();
        chk("t5_iss_valid", 128'(ifc.iss_valid), 128'(0));
        chk("t5_busy", 128'(ifc.busy_o), 128'(0));
        ifc.iss_ready = 1'b1;
        tick();
        send_ok(mk(OP_LDW, 13, 1, 0, 0), "t5_mc0_a");
        send_ok(mk(OP_LDW, 14, 1, 0, 0), "t5_mc0_b");
        drive(mk(OP_LDW, 15, 1, 0, 0));
        settle();
        chk("t5_mc_full", 128'(ifc.dec_ready), 128'(0));
        tick();
        ifc.dec_valid = 1'b0;
        wb_pulse(1'b1, 13);
        wb_pulse(1'b1, 14);

        // asynchronous reset mid-stream
        send_ok(mk(OP_LDW, 31, 1, 0, 0), "t6_ld31");
        send_ok(mk(OP_ADD, 30, 1, 2, 0), "t6_acc30");
        ifc.iss_ready = 1'b0;
        settle();
        chk("t6_pre_busy", 128'(ifc.busy_o), (128'(1) << 30) | (128'(1) << 31));
        #1 rst = 1'b0;
        #1;
        chk("t6_iss_valid", 128'(ifc.iss_valid), 128'(0));
        chk("t6_busy", 128'(ifc.busy_o), 128'(0));
        chk("t6_iss_ir", 128'(ifc.iss_ir), 128'(0));
        chk("t6_dec_ready", 128'(ifc.dec_ready), 128'(0));
        exp_q.delete();
        tick();
        rst = 1'b1;
        ifc.iss_ready = 1'b1;
        tick();
        send_ok(mk(OP_LDW, 32, 1, 0, 0), "t6_mc0_a");
        send_ok(mk(OP_LDW, 33, 1, 0, 0), "t6_mc0_b");
        drive(mk(OP_LDW, 34, 1, 0, 0));
        settle();
        chk("t6_mc_full", 128'(ifc.dec_ready), 128'(0));
        tick();
        ifc.dec_valid = 1'b0;
        wb_pulse(1'b1, 32);
        wb_pulse(1'b1, 33);
        settle();
        chk("end_busy", 128'(ifc.busy_o), 128'(0));
        chk("end_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
